// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: pops words from a synchronous FIFO and presents them on a
// valid/ready stream, using a 2-entry skid buffer to hide the FIFO's 1-cycle read latency.
module fifo_stream_reader #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               fifo_empty,
    input  logic [WIDTH-1:0]   fifo_rdata,
    output logic               fifo_ren,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] rd_count,
    output logic               busy
);

    logic [WIDTH-1:0]   head_q, head_d;
    logic [WIDTH-1:0]   tail_q, tail_d;
    logic [1:0]         buf_count_q, buf_count_d;
    logic               inflight_q, inflight_d;
    logic [COUNT_W-1:0] rd_count_q, rd_count_d;
    logic               pop;
    logic [2:0]         occupancy;

    always_comb begin
        out_valid = (buf_count_q != 2'd0);
        pop       = out_valid & out_ready;
        occupancy = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
        // A read is only issued when its returning word is guaranteed a free slot.
        fifo_ren  = reset & en & ~fifo_empty & (occupancy < 3'd2);
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        buf_count_d = buf_count_q;
        inflight_d  = fifo_ren;
        rd_count_d  = rd_count_q + {{(COUNT_W-1){1'b0}}, fifo_ren};
        case ({inflight_q, pop})
            2'b10: begin
                if (buf_count_q == 2'd0) begin
                    head_d = fifo_rdata;
                end else begin
                    tail_d = fifo_rdata;
                end
                buf_count_d = buf_count_q + 2'd1;
            end
            2'b01: begin
                head_d      = tail_q;
                buf_count_d = buf_count_q - 2'd1;
            end
            2'b11: begin
                if (buf_count_q == 2'd1) begin
                    head_d = fifo_rdata;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            buf_count_q <= 2'd0;
            inflight_q  <= 1'b0;
            rd_count_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            buf_count_q <= buf_count_d;
            inflight_q  <= inflight_d;
            rd_count_q  <= rd_count_d;
        end
    end

    assign out_data = head_q;
    assign busy     = inflight_q | (buf_count_q != 2'd0);
    assign rd_count = rd_count_q;

endmodule
